// File: rtl/dual_clock_fifo_wrapper.sv
// Single-clock FIFO with Gray-coded pointers passed through LATENCY-deep delay lines,
// so the full/empty flags behave like those of a dual-clock FIFO.
module dual_clock_fifo_wrapper #(
  parameter int    DATA_WIDTH    = 8,
  parameter int    ADDR_WIDTH    = 8,
  parameter int    LATENCY       = 2,
  parameter string FIFO_MODE     = "STD_FIFO",
  parameter string RAM_INIT_FILE = "",
  parameter string COMPATIBILITY = "E",
  parameter string OUTPUT_REG    = "TRUE",
  parameter string CHECK_FULL    = "TRUE",
  parameter string CHECK_EMPTY   = "TRUE"
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam bit USE_OREG      = (OUTPUT_REG == "TRUE") ||
                                 ((OUTPUT_REG == "DONT_CARE") && (COMPATIBILITY != "A"));
  localparam bit USE_CHK_FULL  = (CHECK_FULL != "FALSE");
  localparam bit USE_CHK_EMPTY = (CHECK_EMPTY != "FALSE");
  localparam bit IS_FWFT       = (FIFO_MODE == "FWFT");

  // Full compares against the read pointer with its two top Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         wptr_gray, rptr_gray;
  logic [PW-1:0]         wsync_q [LATENCY];
  logic [PW-1:0]         wsync_d [LATENCY];
  logic [PW-1:0]         rsync_q [LATENCY];
  logic [PW-1:0]         rsync_d [LATENCY];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  we_ok, re_ok;

  always_comb begin
    wptr_gray = wptr_q ^ (wptr_q >> 1);
    rptr_gray = rptr_q ^ (rptr_q >> 1);
    o_empty   = (rptr_gray == wsync_q[LATENCY-1]);
    o_full    = (wptr_gray == (rsync_q[LATENCY-1] ^ FULL_MASK));
    we_ok     = i_we && (!o_full  || !USE_CHK_FULL);
    re_ok     = i_re && (!o_empty || !USE_CHK_EMPTY);
    wptr_d    = wptr_q + {{ADDR_WIDTH{1'b0}}, we_ok};
    rptr_d    = rptr_q + {{ADDR_WIDTH{1'b0}}, re_ok};

    wsync_d[0] = wptr_gray;
    rsync_d[0] = rptr_gray;
    for (int i = 1; i < LATENCY; i++) begin
      wsync_d[i] = wsync_q[i-1];
      rsync_d[i] = rsync_q[i-1];
    end

    // FWFT keeps the head word loaded every cycle; standard mode loads only on a read.
    if (IS_FWFT) begin
      rd_d = mem_q[rptr_d[ADDR_WIDTH-1:0]];
    end else if (re_ok) begin
      rd_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
    end else begin
      rd_d = rd_q;
    end
    out_d   = rd_q;
    o_rdata = USE_OREG ? out_q : rd_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      rd_q   <= '0;
      out_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        wsync_q[i] <= '0;
        rsync_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      rd_q   <= rd_d;
      out_q  <= out_d;
      for (int i = 0; i < LATENCY; i++) begin
        wsync_q[i] <= wsync_d[i];
        rsync_q[i] <= rsync_d[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (we_ok) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= i_wdata;
    end
  end

endmodule

// File: tb/tb_dual_clock_fifo_wrapper.sv
// Scoreboard bench: a default instance (read latency 2) and a COMPATIBILITY="A" instance
// (read latency 1) share one stimulus stream; monitors pop expected words as data appears.
module tb_dual_clock_fifo_wrapper;

  logic       clk = 1'b0;
  logic       rstn;
  logic       we;
  logic       re;
  logic [7:0] wdata;
  logic       full_a, empty_a, full_b, empty_b;
  logic [7:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic       pend_a1 = 1'b0;
  logic       pend_a2 = 1'b0;
  logic       pend_b1 = 1'b0;

  always #5 clk = ~clk;

  dual_clock_fifo_wrapper u_a (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_we    (we),
    .i_wdata (wdata),
    .i_re    (re),
    .o_full  (full_a),
    .o_empty (empty_a),
    .o_rdata (rdata_a)
  );

  dual_clock_fifo_wrapper #(
    .COMPATIBILITY ("A"),
    .OUTPUT_REG    ("DONT_CARE")
  ) u_b (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_we    (we),
    .i_wdata (wdata),
    .i_re    (re),
    .o_full  (full_b),
    .o_empty (empty_b),
    .o_rdata (rdata_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic popAndCheck(input string name, input logic [7:0] actual, input bit is_a);
    logic [7:0] e;
    if (is_a ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected word actual=%0h expected=none", name, actual);
    end else begin
      e = is_a ? exp_a.pop_front() : exp_b.pop_front();
      checkOutput(name, actual, e);
    end
  endtask

  // A read is accepted on the edge after a negedge that sees i_re=1 and o_empty=0;
  // its word is visible one (u_b) or two (u_a) negedges later.
  always @(negedge clk) begin
    if (!rstn) begin
      pend_a1 = 1'b0;
      pend_a2 = 1'b0;
      pend_b1 = 1'b0;
    end else begin
      if (pend_a2) popAndCheck("rdata_a", rdata_a, 1'b1);
      if (pend_b1) popAndCheck("rdata_b", rdata_b, 1'b0);
      pend_a2 = pend_a1;
      pend_a1 = re && !empty_a;
      pend_b1 = re && !empty_b;
    end
  end

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input bit accept);
    we    = w;
    wdata = d;
    re    = r;
    if (w && accept) begin
      exp_a.push_back(d);
      exp_b.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    rstn = 1'b0;
    we   = 1'b0;
    re   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic checkIdle(input string name, input int rdata_exp);
    checkOutput({name, "_empty_a"}, empty_a, 1);
    checkOutput({name, "_full_a"},  full_a,  0);
    checkOutput({name, "_rdata_a"}, rdata_a, rdata_exp);
    checkOutput({name, "_empty_b"}, empty_b, 1);
    checkOutput({name, "_full_b"},  full_b,  0);
    checkOutput({name, "_rdata_b"}, rdata_b, rdata_exp);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_left_a"}, exp_a.size(), 0);
    checkOutput({name, "_left_b"}, exp_b.size(), 0);
  endtask

  initial begin
    rstn  = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    wdata = 8'h00;
    doReset(3);

    // Reset then idle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkIdle("idle", 0);
    end

    // Streaming writes 0x01..0x11 with reads held high.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 1'b1, 1'b1);
      checkOutput("stream_empty_a", empty_a, (i < 2) ? 1 : 0);
      checkOutput("stream_empty_b", empty_b, (i < 2) ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_end_empty_a", empty_a, 1);
    checkOutput("stream_end_empty_b", empty_b, 1);
    checkDrained("stream");

    // Fill 256 words, then try four overflowing writes.
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b1);
      checkOutput("fill_full_a", full_a, (k == 255) ? 1 : 0);
      checkOutput("fill_full_b", full_b, (k == 255) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      checkOutput("overflow_full_a", full_a, 1);
      checkOutput("overflow_full_b", full_b, 1);
    end
    checkOutput("fill_empty_a", empty_a, 0);

    // Drain all 256 words.
    for (int j = 0; j < 256; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_full_a",  full_a,  (j < 2) ? 1 : 0);
      checkOutput("drain_full_b",  full_b,  (j < 2) ? 1 : 0);
      checkOutput("drain_empty_a", empty_a, (j == 255) ? 1 : 0);
      checkOutput("drain_empty_b", empty_b, (j == 255) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkDrained("drain");

    // Underflow pulse must leave the last read word (0xFF) on the output.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("underflow_rdata_a", rdata_a, 8'hFF);
    checkOutput("underflow_rdata_b", rdata_b, 8'hFF);
    checkOutput("underflow_empty_a", empty_a, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkDrained("after_underflow");

    // Reset mid-operation discards stored words.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b1);
    doReset(2);
    checkIdle("midreset", 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("midreset_read_empty_a", empty_a, 1);
      checkOutput("midreset_read_empty_b", empty_b, 1);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkIdle("midreset_end", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
